hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_fwd_sel.sv | 38 +++
 rtl/hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================
// Package : hazard_pkg
// Brief   : Shared forward-select encodings and control FSM state type.
// Rev     : 1.0
// ============================================================
package hazard_pkg;

    localparam logic [1:0] c_fwdRegFile = 2'b00;
    localparam logic [1:0] c_fwdMem     = 2'b10;
    localparam logic [1:0] c_fwdWb      = 2'b01;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hzState_t;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================
// Module : hazard_fwd_sel
// Brief  : One source operand's forward select and load-use match.
// Rev    : 1.0
// ============================================================
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_regwriteM,
    input  logic              i_regwriteW,
    input  logic              i_isloadE,
    input  logic [REG_AW-1:0] i_rdE,
    input  logic [REG_AW-1:0] i_rdM,
    input  logic [REG_AW-1:0] i_rdW,
    input  logic [REG_AW-1:0] i_rsD,
    input  logic [REG_AW-1:0] i_rsE,
    input  logic              i_srcValidD,
    output logic [1:0]        o_fwdSel,
    output logic              o_loadUseHit
);

    // Register 0 is hardwired, so a write to it never produces a hazard.
    always_comb begin
        o_fwdSel = c_fwdRegFile;
        if (i_regwriteM && (i_rdM != '0) && (i_rdM == i_rsE)) begin
            o_fwdSel = c_fwdMem;
        end else if (i_regwriteW && (i_rdW != '0) && (i_rdW == i_rsE)) begin
            o_fwdSel = c_fwdWb;
        end
    end

    assign o_loadUseHit = i_srcValidD && i_isloadE && (i_rdE != '0) && (i_rdE == i_rsD);

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================
// Module : hazard_ctrl
// Brief  : Forwarding, load-use stall, branch flush and multi-cycle
//          op sequencing for a five-stage pipeline.
// Rev    : 1.0
// ============================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int FLUSH_EXTRA = 0,
    parameter int MC_TIMEOUT  = 64,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      regwriteM,
    input  logic                      regwriteW,
    input  logic                      isloadE,
    input  logic [REG_AW-1:0]         rdE,
    input  logic [REG_AW-1:0]         rdM,
    input  logic [REG_AW-1:0]         rdW,
    input  logic [NUM_SRC*REG_AW-1:0] rsD,
    input  logic [NUM_SRC*REG_AW-1:0] rsE,
    input  logic [NUM_SRC-1:0]        srcvalidD,
    input  logic                      isbranchtakenE,
    input  logic                      mc_startE,
    input  logic                      mc_doneE,
    output logic [2*NUM_SRC-1:0]      forwardE,
    output logic                      stallF,
    output logic                      stallD,
    output logic                      stallE,
    output logic                      flushD,
    output logic                      flushE,
    output logic                      mc_err,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int                  c_busyW      = $clog2(MC_TIMEOUT + 1);
    localparam logic [c_busyW-1:0]  c_busyLast   = c_busyW'(MC_TIMEOUT - 1);
    localparam logic [1:0]          c_flushExtra = 2'(FLUSH_EXTRA);

    hzState_t               r_state;
    logic [c_busyW-1:0]     r_busyCnt;
    logic [1:0]             r_flushExt;
    logic                   r_mcErr;
    logic [CNT_W-1:0]       r_stallCnt;
    logic [CNT_W-1:0]       r_flushCnt;
    logic [2*NUM_SRC-1:0]   r_fwdHold;

    logic [2*NUM_SRC-1:0]   w_fwdLive;
    logic [NUM_SRC-1:0]     w_luHit;
    logic                   w_idle;
    logic                   w_branch;
    logic                   w_stallLU;
    logic                   w_stallF;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        hazard_fwd_sel #(
            .REG_AW (REG_AW)
        ) u_fwdSel (
            .i_regwriteM  (regwriteM),
            .i_regwriteW  (regwriteW),
            .i_isloadE    (isloadE),
            .i_rdE        (rdE),
            .i_rdM        (rdM),
            .i_rdW        (rdW),
            .i_rsD        (rsD[gi*REG_AW +: REG_AW]),
            .i_rsE        (rsE[gi*REG_AW +: REG_AW]),
            .i_srcValidD  (srcvalidD[gi]),
            .o_fwdSel     (w_fwdLive[2*gi +: 2]),
            .o_loadUseHit (w_luHit[gi])
        );
    end

    // A taken branch squashes the dependent instruction, so it masks load-use.
    assign w_idle    = (r_state == IDLE);
    assign w_branch  = w_idle && isbranchtakenE;
    assign w_stallLU = w_idle && (|w_luHit) && !isbranchtakenE;
    assign w_stallF  = !w_idle || w_stallLU;

    always_comb begin
        forwardE  = '0;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        mc_err    = 1'b0;
        stall_cnt = '0;
        flush_cnt = '0;
        if (rst) begin
            forwardE  = w_idle ? w_fwdLive : r_fwdHold;
            stallF    = w_stallF;
            stallD    = w_stallF;
            stallE    = !w_idle;
            flushD    = w_branch || (r_flushExt != 2'd0);
            flushE    = w_branch || w_stallLU;
            mc_err    = r_mcErr;
            stall_cnt = r_stallCnt;
            flush_cnt = r_flushCnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_busyCnt  <= '0;
            r_flushExt <= 2'd0;
            r_mcErr    <= 1'b0;
            r_stallCnt <= '0;
            r_flushCnt <= '0;
            r_fwdHold  <= '0;
        end else begin
            // The E-stage selection is frozen for the duration of a BUSY stretch.
            if (w_idle) begin
                r_fwdHold <= w_fwdLive;
            end
            if (w_stallF && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_branch && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
            if (w_branch) begin
                r_flushExt <= c_flushExtra;
            end else if (r_flushExt != 2'd0) begin
                r_flushExt <= r_flushExt - 2'd1;
            end
            case (r_state)
                IDLE: begin
                    if (mc_startE) begin
                        r_state   <= BUSY;
                        r_busyCnt <= '0;
                    end
                end
                BUSY: begin
                    if (mc_doneE) begin
                        r_state <= IDLE;
                    end else if (r_busyCnt == c_busyLast) begin
                        r_state <= IDLE;
                        r_mcErr <= 1'b1;
                    end else begin
                        r_busyCnt <= r_busyCnt + c_busyW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================
// Module : tb_hazard_ctrl
// Brief  : Directed self-checking bench for hazard_ctrl.
// Rev    : 1.0
// ============================================================
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int NUM_SRC = 2;

    logic                      clk;
    logic                      rst;
    logic                      regwriteM, regwriteW, isloadE;
    logic [REG_AW-1:0]         rdE, rdM, rdW;
    logic [NUM_SRC*REG_AW-1:0] rsD, rsE;
    logic [NUM_SRC-1:0]        srcvalidD;
    logic                      isbranchtakenE, mc_startE, mc_doneE;
    logic [2*NUM_SRC-1:0]      forwardE;
    logic                      stallF, stallD, stallE, flushD, flushE, mc_err;
    logic [15:0]               stall_cnt, flush_cnt;

    int nTests = 0;
    int nFail  = 0;

    hazard_ctrl #(
        .REG_AW      (REG_AW),
        .NUM_SRC     (NUM_SRC),
        .FLUSH_EXTRA (2),
        .MC_TIMEOUT  (8),
        .CNT_W       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .regwriteM      (regwriteM),
        .regwriteW      (regwriteW),
        .isloadE        (isloadE),
        .rdE            (rdE),
        .rdM            (rdM),
        .rdW            (rdW),
        .rsD            (rsD),
        .rsE            (rsE),
        .srcvalidD      (srcvalidD),
        .isbranchtakenE (isbranchtakenE),
        .mc_startE      (mc_startE),
        .mc_doneE       (mc_doneE),
        .forwardE       (forwardE),
        .stallF         (stallF),
        .stallD         (stallD),
        .stallE         (stallE),
        .flushD         (flushD),
        .flushE         (flushE),
        .mc_err         (mc_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        regwriteM = 0; regwriteW = 0; isloadE = 0;
        rdE = '0; rdM = '0; rdW = '0; rsD = '0; rsE = '0; srcvalidD = '0;
        isbranchtakenE = 0; mc_startE = 0; mc_doneE = 0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearIn();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearIn();
        regwriteM = 1; rdM = 5'd5; rsE = {5'd0, 5'd5};
        isbranchtakenE = 1; isloadE = 1; rdE = 5'd5; rsD = {5'd0, 5'd5}; srcvalidD = 2'b01;
        step();
        nTests++; if (forwardE !== 4'b0000) begin nFail++; $display("FAIL rst_forwardE got=%b exp=0000", forwardE); end
        nTests++; if ({stallF, stallD, stallE, flushD, flushE, mc_err} !== 6'b0) begin nFail++; $display("FAIL rst_ctrl got=%b exp=000000", {stallF, stallD, stallE, flushD, flushE, mc_err}); end
        nTests++; if ({stall_cnt, flush_cnt} !== 32'h0) begin nFail++; $display("FAIL rst_counters got=%h exp=0", {stall_cnt, flush_cnt}); end
        rst = 1'b1;
        clearIn();
        #1;
        nTests++; if ({stallF, flushD, stallE} !== 3'b000) begin nFail++; $display("FAIL rst_release got=%b exp=000", {stallF, flushD, stallE}); end
    endtask

    task automatic test_forward();
        doReset();
        regwriteM = 1; rdM = 5'd5; regwriteW = 1; rdW = 5'd5; rsE = {5'd0, 5'd5};
        #1;
        nTests++; if (forwardE !== 4'b0010) begin nFail++; $display("FAIL fwd_m_over_w got=%b exp=0010", forwardE); end
        rdM = 5'd0;
        #1;
        nTests++; if (forwardE !== 4'b0001) begin nFail++; $display("FAIL fwd_rdm_zero got=%b exp=0001", forwardE); end
        rdM = 5'd3; rdW = 5'd9; rsE = {5'd3, 5'd9};
        #1;
        nTests++; if (forwardE !== 4'b1001) begin nFail++; $display("FAIL fwd_mixed got=%b exp=1001", forwardE); end
        regwriteM = 0; regwriteW = 0;
        #1;
        nTests++; if (forwardE !== 4'b0000) begin nFail++; $display("FAIL fwd_no_write got=%b exp=0000", forwardE); end
        regwriteW = 1; rdW = 5'd0; rsE = {5'd0, 5'd0};
        #1;
        nTests++; if (forwardE !== 4'b0000) begin nFail++; $display("FAIL fwd_r0 got=%b exp=0000", forwardE); end
        nTests++; if ({stallF, flushE} !== 2'b00) begin nFail++; $display("FAIL fwd_no_stall got=%b exp=00", {stallF, flushE}); end
    endtask

    task automatic test_load_use();
        doReset();
        isloadE = 1; rdE = 5'd7; rsD = {5'd7, 5'd3}; srcvalidD = 2'b10;
        #1;
        nTests++; if ({stallF, stallD, flushE, flushD, stallE} !== 5'b11100) begin nFail++; $display("FAIL lu_hit got=%b exp=11100", {stallF, stallD, flushE, flushD, stallE}); end
        step();
        clearIn();
        #1;
        nTests++; if ({stallF, stallD, flushE} !== 3'b000) begin nFail++; $display("FAIL lu_one_cycle got=%b exp=000", {stallF, stallD, flushE}); end
        nTests++; if (stall_cnt !== 16'd1) begin nFail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        isloadE = 1; rdE = 5'd7; rsD = {5'd7, 5'd3}; srcvalidD = 2'b01;
        #1;
        nTests++; if ({stallF, stallD, flushE} !== 3'b000) begin nFail++; $display("FAIL lu_masked got=%b exp=000", {stallF, stallD, flushE}); end
        rdE = 5'd0; rsD = {5'd0, 5'd0}; srcvalidD = 2'b11;
        #1;
        nTests++; if (stallF !== 1'b0) begin nFail++; $display("FAIL lu_r0 got=%b exp=0", stallF); end
    endtask

    task automatic test_branch_priority();
        doReset();
        isloadE = 1; rdE = 5'd7; rsD = {5'd7, 5'd0}; srcvalidD = 2'b10; isbranchtakenE = 1;
        #1;
        nTests++; if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin nFail++; $display("FAIL br_prio got=%b exp=0011", {stallF, stallD, flushD, flushE}); end
        step();
        clearIn();
        #1;
        nTests++; if ({flushD, flushE} !== 2'b10) begin nFail++; $display("FAIL br_ext1 got=%b exp=10", {flushD, flushE}); end
        nTests++; if (flush_cnt !== 16'd1) begin nFail++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_cnt); end
        step();
        nTests++; if (flushD !== 1'b1) begin nFail++; $display("FAIL br_ext2 got=%b exp=1", flushD); end
        step();
        nTests++; if (flushD !== 1'b0) begin nFail++; $display("FAIL br_ext_end got=%b exp=0", flushD); end
        nTests++; if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) begin nFail++; $display("FAIL br_counters got=%h exp=00000001", {stall_cnt, flush_cnt}); end
    endtask

    task automatic test_back_to_back();
        doReset();
        isbranchtakenE = 1;
        step();
        step();
        isbranchtakenE = 0;
        #1;
        nTests++; if (flushD !== 1'b1) begin nFail++; $display("FAIL b2b_ext1 got=%b exp=1", flushD); end
        nTests++; if (flush_cnt !== 16'd2) begin nFail++; $display("FAIL b2b_flush_cnt got=%0d exp=2", flush_cnt); end
        step();
        nTests++; if (flushD !== 1'b1) begin nFail++; $display("FAIL b2b_ext2 got=%b exp=1", flushD); end
        step();
        nTests++; if (flushD !== 1'b0) begin nFail++; $display("FAIL b2b_end got=%b exp=0", flushD); end
    endtask

    task automatic test_multicycle();
        doReset();
        mc_startE = 1; mc_doneE = 1;
        regwriteM = 1; rdM = 5'd4; rsE = {5'd0, 5'd4};
        #1;
        nTests++; if ({stallE, stallF, forwardE} !== 6'b000010) begin nFail++; $display("FAIL mc_start_cycle got=%b exp=000010", {stallE, stallF, forwardE}); end
        step();
        clearIn();
        for (int k = 1; k <= 4; k++) begin
            isbranchtakenE = (k == 1);
            isloadE = (k == 2); rdE = 5'd6; rsD = {5'd0, 5'd6}; srcvalidD = 2'b01;
            mc_startE = (k == 3);
            mc_doneE = (k == 4);
            #1;
            nTests++; if ({stallF, stallD, stallE} !== 3'b111) begin nFail++; $display("FAIL mc_busy_stall_%0d got=%b exp=111", k, {stallF, stallD, stallE}); end
            nTests++; if ({flushD, flushE} !== 2'b00) begin nFail++; $display("FAIL mc_busy_flush_%0d got=%b exp=00", k, {flushD, flushE}); end
            nTests++; if (forwardE !== 4'b0010) begin nFail++; $display("FAIL mc_hold_fwd_%0d got=%b exp=0010", k, forwardE); end
            step();
        end
        clearIn();
        #1;
        nTests++; if ({stallE, stallF} !== 2'b00) begin nFail++; $display("FAIL mc_done_idle got=%b exp=00", {stallE, stallF}); end
        nTests++; if (stall_cnt !== 16'd4) begin nFail++; $display("FAIL mc_stall_cnt got=%0d exp=4", stall_cnt); end
        nTests++; if ({mc_err, flush_cnt} !== 17'd0) begin nFail++; $display("FAIL mc_err_flush got=%h exp=0", {mc_err, flush_cnt}); end
    endtask

    task automatic test_timeout();
        doReset();
        mc_startE = 1;
        step();
        clearIn();
        for (int k = 1; k <= 8; k++) begin
            #1;
            nTests++; if (stallE !== 1'b1) begin nFail++; $display("FAIL to_busy_%0d got=%b exp=1", k, stallE); end
            step();
        end
        #1;
        nTests++; if ({stallE, mc_err} !== 2'b01) begin nFail++; $display("FAIL to_expire got=%b exp=01", {stallE, mc_err}); end
        nTests++; if (stall_cnt !== 16'd8) begin nFail++; $display("FAIL to_stall_cnt got=%0d exp=8", stall_cnt); end
        step();
        step();
        nTests++; if (mc_err !== 1'b1) begin nFail++; $display("FAIL to_sticky got=%b exp=1", mc_err); end
        mc_startE = 1;
        step();
        mc_startE = 0;
        step();
        nTests++; if (stallE !== 1'b1) begin nFail++; $display("FAIL to_rebusy got=%b exp=1", stallE); end
        rst = 1'b0;
        step();
        nTests++; if ({stallF, stallD, stallE, flushD, flushE, mc_err} !== 6'b0) begin nFail++; $display("FAIL to_rst_outputs got=%b exp=000000", {stallF, stallD, stallE, flushD, flushE, mc_err}); end
        rst = 1'b1;
        #1;
        nTests++; if ({stallE, mc_err, stall_cnt} !== 18'd0) begin nFail++; $display("FAIL to_after_rst got=%h exp=0", {stallE, mc_err, stall_cnt}); end
    endtask

    initial begin
        rst = 1'b0;
        clearIn();
        test_reset();
        test_forward();
        test_load_use();
        test_branch_priority();
        test_back_to_back();
        test_multicycle();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
